// File: rtl/spi_txn_arbiter_if.sv
// Request/grant and SPI engine handshake bundle for spi_txn_arbiter.
// The slave modport is the arbiter's view; master is the requester/engine side.
interface spi_txn_arbiter_if #(
    parameter int NUM_REQ  = 3,
    parameter int NUM_BITS = 8
);
    logic [NUM_REQ-1:0]          req_i;
    logic [NUM_REQ*NUM_BITS-1:0] req_addr_i;
    logic [NUM_REQ*NUM_BITS-1:0] req_wdata_i;
    logic [NUM_REQ-1:0]          gnt_o;
    logic [NUM_REQ-1:0]          ack_o;
    logic [NUM_REQ-1:0]          err_o;
    logic [NUM_BITS-1:0]         rdata_o;
    logic                        spi_start_o;
    logic [NUM_BITS-1:0]         spi_addr_o;
    logic [NUM_BITS-1:0]         spi_wdata_o;
    logic [2:0]                  spi_cs_o;
    logic                        spi_done_i;
    logic [NUM_BITS-1:0]         spi_rdata_i;

    modport slave (
        input  req_i, req_addr_i, req_wdata_i, spi_done_i, spi_rdata_i,
        output gnt_o, ack_o, err_o, rdata_o, spi_start_o, spi_addr_o,
               spi_wdata_o, spi_cs_o
    );

    modport master (
        output req_i, req_addr_i, req_wdata_i, spi_done_i, spi_rdata_i,
        input  gnt_o, ack_o, err_o, rdata_o, spi_start_o, spi_addr_o,
               spi_wdata_o, spi_cs_o
    );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that hands one requester at a time to a single SPI engine,
// with a bounded wait for the engine's completion pulse.
module spi_txn_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int NUM_BITS = 8,
    parameter int TIMEOUT  = 255
) (
    input logic pclk_i,
    input logic prst_i,
    spi_txn_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);
    localparam logic [7:0]       TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [5:0] {
        ST_IDLE     = 6'b000001,
        ST_GRANT    = 6'b000010,
        ST_START    = 6'b000100,
        ST_WAIT     = 6'b001000,
        ST_COMPLETE = 6'b010000,
        ST_ERROR    = 6'b100000
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    last_gnt;
    logic [IDX_W-1:0]    winner;
    logic [IDX_W-1:0]    pick;
    logic [IDX_W-1:0]    cand;
    logic                found;
    logic [7:0]          count;
    logic [NUM_REQ-1:0]  pick_onehot;
    logic [NUM_BITS-1:0] addr_arr  [NUM_REQ];
    logic [NUM_BITS-1:0] wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign addr_arr[g]  = bus.req_addr_i[g*NUM_BITS +: NUM_BITS];
        assign wdata_arr[g] = bus.req_wdata_i[g*NUM_BITS +: NUM_BITS];
    end

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_gnt) + k) % NUM_REQ);
            if (!found && bus.req_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign pick_onehot = NUM_REQ'(1) << pick;

    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            state           <= ST_IDLE;
            last_gnt        <= LAST_IDX;
            winner          <= '0;
            count           <= '0;
            bus.gnt_o       <= '0;
            bus.ack_o       <= '0;
            bus.err_o       <= '0;
            bus.rdata_o     <= '0;
            bus.spi_start_o <= 1'b0;
            bus.spi_addr_o  <= '0;
            bus.spi_wdata_o <= '0;
            bus.spi_cs_o    <= '0;
        end else begin
            bus.ack_o       <= '0;
            bus.err_o       <= '0;
            bus.spi_start_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (found) begin
                        winner          <= pick;
                        bus.gnt_o       <= pick_onehot;
                        bus.spi_cs_o    <= 3'(pick_onehot);
                        bus.spi_addr_o  <= addr_arr[pick];
                        bus.spi_wdata_o <= wdata_arr[pick];
                        state           <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    bus.spi_start_o <= 1'b1;
                    state           <= ST_START;
                end
                ST_START: begin
                    count <= '0;
                    state <= ST_WAIT;
                end
                // A done arriving on the timeout cycle still counts as a completion.
                ST_WAIT: begin
                    if (bus.spi_done_i) begin
                        if (!bus.spi_addr_o[7]) begin
                            bus.rdata_o <= bus.spi_rdata_i;
                        end
                        bus.ack_o <= bus.gnt_o;
                        state     <= ST_COMPLETE;
                    end else if (count == TIMEOUT_CNT) begin
                        bus.err_o <= bus.gnt_o;
                        state     <= ST_ERROR;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                ST_COMPLETE, ST_ERROR: begin
                    bus.gnt_o    <= '0;
                    bus.spi_cs_o <= '0;
                    last_gnt     <= winner;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Randomised bench for spi_txn_arbiter, checked against a transaction-level
// model of round-robin order, latencies, timeout and read-data retention.
module tb_spi_txn_arbiter;
    localparam int NREQ  = 3;
    localparam int NBITS = 8;
    localparam int TMO   = 255;

    logic clk = 1'b0;
    logic rstN;

    always #5 clk = ~clk;

    spi_txn_arbiter_if #(.NUM_REQ(NREQ), .NUM_BITS(NBITS)) bus();

    spi_txn_arbiter #(.NUM_REQ(NREQ), .NUM_BITS(NBITS), .TIMEOUT(TMO)) dut (
        .pclk_i(clk),
        .prst_i(rstN),
        .bus   (bus.slave)
    );

    int compareCount  = 0;
    int mismatchCount = 0;
    int lastGnt;
    logic [NBITS-1:0] expRdata;
    logic [NBITS-1:0] addrTab  [NREQ];
    logic [NBITS-1:0] wdataTab [NREQ];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Round-robin winner computed directly from the arbitration rule.
    function automatic int modelWinner(input logic [NREQ-1:0] mask);
        for (int k = 1; k <= NREQ; k++) begin
            if (mask[(lastGnt + k) % NREQ]) return (lastGnt + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic applyStimulus(input logic [NREQ-1:0] mask);
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr_i[i*NBITS +: NBITS]  = addrTab[i];
            bus.req_wdata_i[i*NBITS +: NBITS] = wdataTab[i];
        end
        bus.req_i = mask;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_gnt"},   32'(bus.gnt_o),       32'd0);
        checkOutput({tag, "_ack"},   32'(bus.ack_o),       32'd0);
        checkOutput({tag, "_err"},   32'(bus.err_o),       32'd0);
        checkOutput({tag, "_rdata"}, 32'(bus.rdata_o),     32'd0);
        checkOutput({tag, "_start"}, 32'(bus.spi_start_o), 32'd0);
        checkOutput({tag, "_addr"},  32'(bus.spi_addr_o),  32'd0);
        checkOutput({tag, "_wdata"}, 32'(bus.spi_wdata_o), 32'd0);
        checkOutput({tag, "_cs"},    32'(bus.spi_cs_o),    32'd0);
    endtask

    task automatic doReset();
        rstN = 1'b0;
        bus.req_i = '0;
        bus.spi_done_i = 1'b0;
        bus.spi_rdata_i = '0;
        lastGnt  = NREQ - 1;
        expRdata = '0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rstN = 1'b1;
        @(negedge clk);
    endtask

    // Entered at the negedge of the cycle where req_i is first sampled;
    // doneDelay = cycles into WAIT before done, negative means never.
    task automatic runTxn(input int doneDelay, input logic [NBITS-1:0] engineData,
                          input bit dropReq, input bit noise, input bit holdReq);
        int win;
        logic [NREQ-1:0] oh;
        bit isWrite;
        bit timedOut;
        int endCycle;
        win = modelWinner(bus.req_i);
        if (win < 0) begin
            checkOutput("txn_no_request", 32'(bus.req_i), 32'd1);
            return;
        end
        oh = NREQ'(1) << win;
        isWrite = addrTab[win][7];
        bus.spi_done_i  = noise ? 1'($urandom) : 1'b0;
        bus.spi_rdata_i = 8'($urandom);
        @(negedge clk);
        checkOutput("grant_gnt",   32'(bus.gnt_o),       32'(oh));
        checkOutput("grant_cs",    32'(bus.spi_cs_o),    32'(oh));
        checkOutput("grant_start", 32'(bus.spi_start_o), 32'd0);
        checkOutput("grant_addr",  32'(bus.spi_addr_o),  32'(addrTab[win]));
        checkOutput("grant_wdata", 32'(bus.spi_wdata_o), 32'(wdataTab[win]));
        if (dropReq) bus.req_i = '0;
        bus.spi_done_i = noise ? 1'($urandom) : 1'b0;
        @(negedge clk);
        checkOutput("start_pulse", 32'(bus.spi_start_o), 32'd1);
        checkOutput("start_gnt",   32'(bus.gnt_o),       32'(oh));
        bus.spi_done_i = noise ? 1'($urandom) : 1'b0;
        @(negedge clk);
        timedOut = !(doneDelay >= 0 && doneDelay <= TMO);
        endCycle = timedOut ? TMO : doneDelay;
        for (int c = 0; c <= endCycle; c++) begin
            if (c > 0) @(negedge clk);
            checkOutput("wait_no_resp", 32'({bus.ack_o, bus.err_o, bus.spi_start_o}), 32'd0);
            checkOutput("wait_gnt", 32'(bus.gnt_o), 32'(oh));
            bus.spi_done_i  = !timedOut && (c == doneDelay);
            bus.spi_rdata_i = bus.spi_done_i ? engineData : 8'($urandom);
        end
        @(negedge clk);
        bus.spi_done_i = 1'b0;
        if (timedOut) begin
            checkOutput("err_pulse", 32'(bus.err_o), 32'(oh));
            checkOutput("err_no_ack", 32'(bus.ack_o), 32'd0);
        end else begin
            if (!isWrite) expRdata = engineData;
            checkOutput("ack_pulse", 32'(bus.ack_o), 32'(oh));
            checkOutput("ack_no_err", 32'(bus.err_o), 32'd0);
        end
        checkOutput("end_rdata", 32'(bus.rdata_o), 32'(expRdata));
        checkOutput("end_gnt",   32'(bus.gnt_o),   32'(oh));
        lastGnt = win;
        if (!holdReq) bus.req_i = bus.req_i & ~oh;
        @(negedge clk);
        checkOutput("idle_gnt", 32'(bus.gnt_o), 32'd0);
        checkOutput("idle_cs",  32'(bus.spi_cs_o), 32'd0);
        checkOutput("idle_resp", 32'({bus.ack_o, bus.err_o}), 32'd0);
        checkOutput("idle_rdata", 32'(bus.rdata_o), 32'(expRdata));
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            addrTab[i]  = '0;
            wdataTab[i] = '0;
        end
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        doReset();

        // Directed: single read, write, timeout, done exactly at the limit.
        addrTab[0] = 8'h05;
        applyStimulus(3'b001);
        runTxn(10, 8'hA5, 1'b0, 1'b0, 1'b0);
        addrTab[1] = 8'h83;
        wdataTab[1] = 8'h3C;
        applyStimulus(3'b010);
        runTxn(3, 8'h77, 1'b0, 1'b0, 1'b0);
        addrTab[2] = 8'h11;
        applyStimulus(3'b100);
        runTxn(-1, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b001);
        runTxn(TMO, 8'h5A, 1'b0, 1'b0, 1'b0);

        // Held contention from reset visits 0,1,2,0.
        doReset();
        applyStimulus(3'b111);
        for (int t = 0; t < 4; t++) runTxn(4, 8'($urandom), 1'b0, 1'b0, 1'b1);
        bus.req_i = '0;
        @(negedge clk);

        // Reset while waiting for the engine, then a stale done.
        applyStimulus(3'b010);
        repeat (4) @(negedge clk);
        #1 rstN = 1'b0;
        #1 checkAllZero("async_rst");
        bus.req_i = '0;
        lastGnt  = NREQ - 1;
        expRdata = '0;
        @(negedge clk);
        rstN = 1'b1;
        bus.spi_done_i  = 1'b1;
        bus.spi_rdata_i = 8'hEE;
        @(negedge clk);
        bus.spi_done_i = 1'b0;
        checkOutput("stale_done_resp", 32'({bus.ack_o, bus.err_o, bus.gnt_o}), 32'd0);
        @(negedge clk);
        checkOutput("stale_done_rdata", 32'(bus.rdata_o), 32'd0);

        // Randomised transactions.
        for (int n = 0; n < 60; n++) begin
            logic [NREQ-1:0] mask;
            int r;
            int delay;
            mask = NREQ'($urandom_range(0, 7));
            for (int i = 0; i < NREQ; i++) begin
                addrTab[i]  = 8'($urandom);
                wdataTab[i] = 8'($urandom);
            end
            applyStimulus(mask);
            if (mask == '0) begin
                @(negedge clk);
                checkOutput("rand_idle_gnt", 32'(bus.gnt_o), 32'd0);
                continue;
            end
            r = $urandom_range(0, 24);
            if (r == 0) delay = -1;
            else if (r == 1) delay = TMO;
            else delay = $urandom_range(0, 12);
            runTxn(delay, 8'($urandom), ($urandom_range(0, 3) == 0),
                   1'($urandom), 1'b0);
            bus.req_i = '0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule
